bf_program_loader: RTL
======================

Name: bf_program_loader

Overview:
- Upstream stage of the brainhack core. Accepts a byte stream of brainfuck source text over a valid/ready handshake.
- Discards non-command characters, encodes the eight commands into instr_width opcodes, and writes them sequentially into program memory.
- Checks bracket balance and capacity while loading, then reports program length.
- Releases the core via o_cpu_run only when the program is fully loaded and valid.

Parameters:
PRGMEM_ADDR_WIDTH, 8, program memory address width; capacity is 2^PRGMEM_ADDR_WIDTH instructions
INSTR_WIDTH, 3, opcode width written to program memory
STACK_ADDR_WIDTH, 4, loop-stack address width; maximum legal nesting depth is 2^STACK_ADDR_WIDTH

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
i_valid  in  1  source byte present on i_byte
o_ready  out  1  loader accepts a byte this cycle
i_byte  in  8  ASCII source byte
i_last  in  1  qualifies final byte of the stream (sampled with i_valid)
i_restart  in  1  single-cycle pulse: begin a new load from DONE or ERROR
o_prgmem_we  out  1  program memory write strobe
o_prgmem_addr  out  PRGMEM_ADDR_WIDTH  write address
o_prgmem_data  out  INSTR_WIDTH  opcode to write
o_prg_len  out  PRGMEM_ADDR_WIDTH+1  number of instructions stored
o_done  out  1  load completed successfully
o_error  out  3  error code, 0 = none
o_cpu_run  out  1  core may execute; 0 holds the core

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State LOAD; count and depth cleared.
  - o_ready=1, o_prgmem_we=0, o_prgmem_addr=0, o_prgmem_data=0, o_prg_len=0, o_done=0, o_error=0, o_cpu_run=0.
  - Reset mid-load abandons the load. Already-written memory is not cleared.
- Handshake:
  - A byte is accepted on a clock edge where i_valid && o_ready.
  - o_ready=1 only in LOAD.
  - i_byte and i_last are ignored when not accepted.
- Opcodes: '+'=000, '-'=001, '>'=010, '<'=011, '['=100, ']'=101, '.'=110, ','=111. Every other byte is a comment: accepted and dropped, with no count or write change.
- Write latency: an accepted command byte produces o_prgmem_we=1 for exactly one cycle on the next cycle, with o_prgmem_addr=count-before-increment and the matching o_prgmem_data. Back-to-back commands give back-to-back writes.
- count: PRGMEM_ADDR_WIDTH+1 bits, increments per stored command. o_prg_len = count.
- depth: STACK_ADDR_WIDTH+1 bits. '[' increments it, ']' decrements it.
- Errors are checked in priority order. The offending byte is not written. State goes to ERROR and o_error holds its code:
  - 1 PRG_FULL: command accepted while count == 2^PRGMEM_ADDR_WIDTH.
  - 2 NEST_OVF: '[' while depth == 2^STACK_ADDR_WIDTH.
  - 3 UNMATCHED_CLOSE: ']' while depth == 0.
  - 4 UNMATCHED_OPEN: i_last accepted and final depth != 0.
  - 5 EMPTY: i_last accepted and final count == 0.
- i_last on a command byte: the byte is processed (written) first, then the end checks run. This is the simultaneous-event rule.
- States:
  - LOAD → DONE on accepted i_last with no error. o_done=1 and o_cpu_run=1 from the next cycle; o_prg_len is frozen.
  - LOAD → ERROR on any error. o_cpu_run stays 0.
  - DONE/ERROR → LOAD on i_restart: count, depth and o_error cleared; o_done=0 and o_cpu_run=0 the next cycle.
  - i_restart while in LOAD is ignored.
- Wrap-around: addresses never wrap. The write to address 2^PRGMEM_ADDR_WIDTH-1 is legal; the next command is PRG_FULL.

Decomposition:
- Package bf_loader_pkg holds:
  - opcode constants (OP_INC … OP_IN)
  - error codes (ERR_NONE … ERR_EMPTY)
  - state encoding (ST_LOAD, ST_DONE, ST_ERROR)
  - ASCII constants for the eight command characters
- Sub-module bf_char_decoder, purely combinational: i_byte → {is_cmd, opcode, is_open, is_close}. The loader instantiates it once.

Test Plan:
- Stream "+[>+<-]." with i_last on '.' → 8 writes at addr 0..7, data 000,100,010,000,011,001,101,110; o_prg_len=8; o_done=1 and o_cpu_run=1 the cycle after the final write.
- Stream "a+ b\n-" with i_valid gaps → only 2 writes (addr 0=000, 1=001); o_prg_len=2; comment bytes accepted with o_ready=1 throughout.
- Stream "+]" → addr 0 written; ']' not written; o_error=3; o_ready=0; o_cpu_run=0; o_prg_len=1.
- Stream "[[" with i_last on the second '[' → both written; o_error=4. Then 5 nested '[' with STACK_ADDR_WIDTH=2 → fifth gives o_error=2.
- PRGMEM_ADDR_WIDTH=2: stream 5 '+' → writes at 0..3; fifth gives o_error=1; o_prg_len=4.
- Assert reset_n=0 mid-stream after 3 commands → next cycle o_prg_len=0, o_ready=1, o_error=0. Pulse i_restart in DONE → returns to LOAD with o_done=0.

Source files
------------

// File: rtl/bf_loader_pkg.sv
// Shared constants for the brainfuck program loader:
// opcodes, error codes, FSM states and command characters.
package bf_loader_pkg;

  localparam logic [2:0] OP_INC   = 3'b000;
  localparam logic [2:0] OP_DEC   = 3'b001;
  localparam logic [2:0] OP_RIGHT = 3'b010;
  localparam logic [2:0] OP_LEFT  = 3'b011;
  localparam logic [2:0] OP_LOOP  = 3'b100;
  localparam logic [2:0] OP_END   = 3'b101;
  localparam logic [2:0] OP_OUT   = 3'b110;
  localparam logic [2:0] OP_IN    = 3'b111;

  localparam logic [2:0] ERR_NONE            = 3'd0;
  localparam logic [2:0] ERR_PRG_FULL        = 3'd1;
  localparam logic [2:0] ERR_NEST_OVF        = 3'd2;
  localparam logic [2:0] ERR_UNMATCHED_CLOSE = 3'd3;
  localparam logic [2:0] ERR_UNMATCHED_OPEN  = 3'd4;
  localparam logic [2:0] ERR_EMPTY           = 3'd5;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] CH_INC   = 8'h2B;
  localparam logic [7:0] CH_DEC   = 8'h2D;
  localparam logic [7:0] CH_RIGHT = 8'h3E;
  localparam logic [7:0] CH_LEFT  = 8'h3C;
  localparam logic [7:0] CH_LOOP  = 8'h5B;
  localparam logic [7:0] CH_END   = 8'h5D;
  localparam logic [7:0] CH_OUT   = 8'h2E;
  localparam logic [7:0] CH_IN    = 8'h2C;

endpackage

// File: rtl/bf_char_decoder.sv
// Combinational source-byte classifier.
// chr -> is_cmd, opcode, is_open ('['), is_close (']').
module bf_char_decoder
  import bf_loader_pkg::*;
(
  input  logic [7:0] chr,
  output logic       is_cmd,
  output logic [2:0] opcode,
  output logic       is_open,
  output logic       is_close
);

  always_comb begin
    is_cmd = 1'b1;
    opcode = OP_INC;
    unique case (chr)
      CH_INC:   opcode = OP_INC;
      CH_DEC:   opcode = OP_DEC;
      CH_RIGHT: opcode = OP_RIGHT;
      CH_LEFT:  opcode = OP_LEFT;
      CH_LOOP:  opcode = OP_LOOP;
      CH_END:   opcode = OP_END;
      CH_OUT:   opcode = OP_OUT;
      CH_IN:    opcode = OP_IN;
      default:  is_cmd = 1'b0;
    endcase
    is_open  = is_cmd && (opcode == OP_LOOP);
    is_close = is_cmd && (opcode == OP_END);
  end

endmodule

// File: rtl/bf_program_loader.sv
// Loads brainfuck source into program memory, checks brackets/capacity.
// Ports: byte stream in (valid/ready/last), restart, memory write, status.
module bf_program_loader
  import bf_loader_pkg::*;
#(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH       = 3,
  parameter int STACK_ADDR_WIDTH  = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [7:0]                   i_byte,
  input  logic                         i_last,
  input  logic                         i_restart,
  output logic                         o_prgmem_we,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  output logic [INSTR_WIDTH-1:0]       o_prgmem_data,
  output logic [PRGMEM_ADDR_WIDTH:0]   o_prg_len,
  output logic                         o_done,
  output logic [2:0]                   o_error,
  output logic                         o_cpu_run
);

  localparam int AW = PRGMEM_ADDR_WIDTH;
  localparam int CW = PRGMEM_ADDR_WIDTH + 1;
  localparam int DW = STACK_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CAP  = {1'b1, {AW{1'b0}}};
  localparam logic [DW-1:0] DMAX = {1'b1, {STACK_ADDR_WIDTH{1'b0}}};

  state_t state, state_n;
  logic [CW-1:0] count, count_n;
  logic [DW-1:0] depth, depth_n;
  logic [2:0] err, err_n, fault;
  logic we, we_n;
  logic [AW-1:0] addr, addr_n;
  logic [INSTR_WIDTH-1:0] data, data_n;
  logic done, done_n;

  logic is_cmd, is_open, is_close;
  logic [2:0] opcode;

  bf_char_decoder u_dec (
    .chr      (i_byte),
    .is_cmd   (is_cmd),
    .opcode   (opcode),
    .is_open  (is_open),
    .is_close (is_close)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_LOAD;
      count <= '0;
      depth <= '0;
      err   <= ERR_NONE;
      we    <= 1'b0;
      addr  <= '0;
      data  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      depth <= depth_n;
      err   <= err_n;
      we    <= we_n;
      addr  <= addr_n;
      data  <= data_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    depth_n = depth;
    err_n   = err;
    we_n    = 1'b0;
    addr_n  = addr;
    data_n  = data;
    fault   = ERR_NONE;
    // Run lags DONE by a cycle so the final write lands first.
    done_n  = (state == ST_DONE) && !i_restart;
    unique case (state)
      ST_LOAD: begin
        if (i_valid) begin
          if (is_cmd) begin
            if (count == CAP)
              fault = ERR_PRG_FULL;
            else if (is_open && depth == DMAX)
              fault = ERR_NEST_OVF;
            else if (is_close && depth == '0)
              fault = ERR_UNMATCHED_CLOSE;
            else begin
              we_n    = 1'b1;
              addr_n  = count[AW-1:0];
              data_n  = INSTR_WIDTH'(opcode);
              count_n = count + CW'(1);
              if (is_open)  depth_n = depth + DW'(1);
              if (is_close) depth_n = depth - DW'(1);
            end
          end
          // End checks see the state after this byte.
          if (fault == ERR_NONE && i_last) begin
            if (depth_n != '0)
              fault = ERR_UNMATCHED_OPEN;
            else if (count_n == '0)
              fault = ERR_EMPTY;
          end
          if (fault != ERR_NONE) begin
            state_n = ST_ERROR;
            err_n   = fault;
          end else if (i_last) begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (i_restart) begin
          state_n = ST_LOAD;
          count_n = '0;
          depth_n = '0;
          err_n   = ERR_NONE;
        end
      end
      default: state_n = ST_LOAD;
    endcase
  end

  assign o_ready       = (state == ST_LOAD);
  assign o_prgmem_we   = we;
  assign o_prgmem_addr = addr;
  assign o_prgmem_data = data;
  assign o_prg_len     = count;
  assign o_done        = done;
  assign o_cpu_run     = done;
  assign o_error       = err;

endmodule
